// File: rtl/cordic_bus_regfile.sv
// Host-side register file for the CORDIC controller: operand/control registers,
// result snapshots captured on each controller interrupt edge, and a sticky maskable irq.
module cordic_bus_regfile #(
  parameter int p_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                addr,
  input  logic                      wrEn,
  input  logic [p_WIDTH-1:0]        wrData,
  input  logic                      rdEn,
  output logic [p_WIDTH-1:0]        rdData,
  output logic                      rdValid,
  output logic                      irq,
  output logic signed [p_WIDTH-1:0] xInput,
  output logic signed [p_WIDTH-1:0] yInput,
  output logic signed [p_WIDTH-1:0] zInput,
  output logic [p_WIDTH-1:0]        controlRegisterInput,
  input  logic signed [p_WIDTH-1:0] xResult,
  input  logic signed [p_WIDTH-1:0] yResult,
  input  logic signed [p_WIDTH-1:0] zResult,
  input  logic [p_WIDTH-1:0]        controlRegisterOutput,
  input  logic [p_WIDTH-1:0]        controlRegisterMask,
  input  logic                      interrupt
);

  localparam logic [2:0] ADDR_X_IN  = 3'd0;
  localparam logic [2:0] ADDR_Y_IN  = 3'd1;
  localparam logic [2:0] ADDR_Z_IN  = 3'd2;
  localparam logic [2:0] ADDR_CTRL  = 3'd3;
  localparam logic [2:0] ADDR_X_RES = 3'd4;
  localparam logic [2:0] ADDR_Y_RES = 3'd5;
  localparam logic [2:0] ADDR_Z_RES = 3'd6;
  localparam logic [2:0] ADDR_IRQ   = 3'd7;

  logic [p_WIDTH-1:0] x_in_reg, y_in_reg, z_in_reg, ctrl_reg, ctrl_next;
  logic [p_WIDTH-1:0] x_res_reg, y_res_reg, z_res_reg;
  logic [p_WIDTH-1:0] rd_data_reg, rd_mux;
  logic               pending_reg, enable_reg, interrupt_q_reg, rd_valid_reg;
  logic               rise, wr_ctrl, wr_irq;

  assign rise    = interrupt & ~interrupt_q_reg;
  assign wr_ctrl = wrEn && (addr == ADDR_CTRL);
  assign wr_irq  = wrEn && (addr == ADDR_IRQ);

  // Controller-owned bits track the controller every cycle; host writes only reach the rest.
  generate
    for (genvar gi = 0; gi < p_WIDTH; gi++) begin : g_ctrl_bit
      assign ctrl_next[gi] = controlRegisterMask[gi] ? controlRegisterOutput[gi] :
                             (wr_ctrl ? wrData[gi] : ctrl_reg[gi]);
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_X_IN:  rd_mux = x_in_reg;
      ADDR_Y_IN:  rd_mux = y_in_reg;
      ADDR_Z_IN:  rd_mux = z_in_reg;
      ADDR_CTRL:  rd_mux = ctrl_reg;
      ADDR_X_RES: rd_mux = x_res_reg;
      ADDR_Y_RES: rd_mux = y_res_reg;
      ADDR_Z_RES: rd_mux = z_res_reg;
      ADDR_IRQ:   rd_mux = {{(p_WIDTH-2){1'b0}}, enable_reg, pending_reg};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_in_reg        <= '0;
      y_in_reg        <= '0;
      z_in_reg        <= '0;
      ctrl_reg        <= '0;
      x_res_reg       <= '0;
      y_res_reg       <= '0;
      z_res_reg       <= '0;
      pending_reg     <= 1'b0;
      enable_reg      <= 1'b0;
      interrupt_q_reg <= 1'b0;
      rd_data_reg     <= '0;
      rd_valid_reg    <= 1'b0;
    end else begin
      interrupt_q_reg <= interrupt;
      ctrl_reg        <= ctrl_next;
      rd_valid_reg    <= rdEn;
      // The mux sees pre-write state, so a same-cycle write never leaks into the read.
      if (rdEn) rd_data_reg <= rd_mux;
      if (wrEn && addr == ADDR_X_IN) x_in_reg <= wrData;
      if (wrEn && addr == ADDR_Y_IN) y_in_reg <= wrData;
      if (wrEn && addr == ADDR_Z_IN) z_in_reg <= wrData;
      if (wr_irq) enable_reg <= wrData[1];
      if (rise) begin
        x_res_reg   <= xResult;
        y_res_reg   <= yResult;
        z_res_reg   <= zResult;
        pending_reg <= 1'b1;
      end else if (wr_irq && wrData[0]) begin
        pending_reg <= 1'b0;
      end
    end
  end

  assign rdData               = rd_data_reg;
  assign rdValid              = rd_valid_reg;
  assign irq                  = pending_reg & enable_reg;
  assign xInput               = x_in_reg;
  assign yInput               = y_in_reg;
  assign zInput               = z_in_reg;
  assign controlRegisterInput = ctrl_reg;

endmodule
